// File: rtl/frame_location_buffer.sv
// Frame-synchronous location/orientation buffer feeding the VGA display writer.
// Optional averaging of same-angle location samples is enabled with `define LOC_FILTER_EN.
module frame_location_buffer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned STALE_FRAMES   = 60,
  parameter logic [11:0] RESET_LOCATION = 12'h000
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic        vsync,
  input  logic [11:0] loc_in,
  input  logic        loc_valid,
  output logic        loc_ready,
  input  logic [5:0]  orient_in,
  input  logic        orient_valid,
  output logic [11:0] location,
  output logic [5:0]  orientation,
  output logic        new_data,
  output logic        orientation_ready,
  output logic        stale,
  output logic        overflow
);

  localparam int unsigned LOC_W   = 12;
  localparam int unsigned ORI_W   = 6;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned STALE_W = 8;

  logic                vsync_d_q;
  logic                frame_tick_c;
  logic [LOC_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push_c, pop_c;
  logic [LOC_W-1:0]    head_c, commit_val_c;
  logic [STALE_W-1:0]  stale_cnt_q, stale_cnt_d;
  logic [LOC_W-1:0]    location_q;
  logic [ORI_W-1:0]    orientation_q, shadow_q;
  logic                pending_q, orient_rdy_q, new_data_q, stale_q, overflow_q;

  // Handshake, FIFO occupancy and frame tick
  always_comb begin
    frame_tick_c = vsync_d_q & ~vsync;
    loc_ready    = (count_q != CNT_W'(DEPTH));
    push_c       = loc_valid & loc_ready;
    pop_c        = frame_tick_c & (count_q != '0);
    head_c       = mem_q[rd_ptr_q];
    count_d      = count_q;
    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
  end

  // Empty frames age the position; a commit makes it fresh again
  always_comb begin
    stale_cnt_d = stale_cnt_q;
    if (pop_c)
      stale_cnt_d = '0;
    else if (frame_tick_c && (stale_cnt_q != STALE_W'(STALE_FRAMES)))
      stale_cnt_d = stale_cnt_q + STALE_W'(1);
  end

`ifdef LOC_FILTER_EN
  logic       committed_q;
  logic [8:0] dist_sum_c;

  // Average distance with the displayed sample when the angle is unchanged
  always_comb begin
    dist_sum_c   = {1'b0, head_c[7:0]} + {1'b0, location_q[7:0]};
    commit_val_c = head_c;
    if (committed_q && (head_c[11:8] == location_q[11:8]))
      commit_val_c = {head_c[11:8], dist_sum_c[8:1]};
  end

  always_ff @(posedge vclock or negedge reset) begin
    if (!reset)     committed_q <= 1'b0;
    else if (pop_c) committed_q <= 1'b1;
  end
`else
  always_comb begin
    commit_val_c = head_c;
  end
`endif

  // Sample storage; contents are don't-care once the pointers are reset
  always_ff @(posedge vclock) begin
    if (push_c) mem_q[wr_ptr_q] <= loc_in;
  end

  always_ff @(posedge vclock or negedge reset) begin
    if (!reset) begin
      vsync_d_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      stale_cnt_q   <= '0;
      stale_q       <= 1'b0;
      location_q    <= RESET_LOCATION;
      new_data_q    <= 1'b0;
      overflow_q    <= 1'b0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      orientation_q <= '0;
      orient_rdy_q  <= 1'b0;
    end else begin
      vsync_d_q   <= vsync;
      count_q     <= count_d;
      stale_cnt_q <= stale_cnt_d;
      stale_q     <= (stale_cnt_d == STALE_W'(STALE_FRAMES));
      new_data_q  <= pop_c;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        location_q <= commit_val_c;
      end
      if (loc_valid && !loc_ready) overflow_q <= 1'b1;
      // Commit uses the pre-edge shadow; a coincident strobe waits a frame
      if (orient_valid) shadow_q <= orient_in;
      if (frame_tick_c && pending_q) begin
        orientation_q <= shadow_q;
        orient_rdy_q  <= 1'b1;
      end
      pending_q <= orient_valid | (pending_q & ~frame_tick_c);
    end
  end

  assign location          = location_q;
  assign orientation       = orientation_q;
  assign new_data          = new_data_q;
  assign orientation_ready = orient_rdy_q;
  assign stale             = stale_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_frame_location_buffer.sv
// Scoreboard bench for frame_location_buffer: commits are queued at push time
// and popped by a monitor on every new_data pulse.
module tb_frame_location_buffer;

  logic        vclock = 1'b0;
  logic        reset, vsync, loc_valid, orient_valid;
  logic [11:0] loc_in;
  logic [5:0]  orient_in;
  logic        loc_ready, new_data, orientation_ready, stale, overflow;
  logic [11:0] location;
  logic [5:0]  orientation;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];
  logic [11:0] m_loc;
  logic        m_first;
  logic [11:0] vals[5];

  frame_location_buffer #(.DEPTH(4), .STALE_FRAMES(3), .RESET_LOCATION(12'h000)) dut (
    .vclock(vclock), .reset(reset), .vsync(vsync),
    .loc_in(loc_in), .loc_valid(loc_valid), .loc_ready(loc_ready),
    .orient_in(orient_in), .orient_valid(orient_valid),
    .location(location), .orientation(orientation), .new_data(new_data),
    .orientation_ready(orientation_ready), .stale(stale), .overflow(overflow)
  );

  always #5 vclock = ~vclock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference for the committed value given the previously committed one
  function automatic logic [11:0] model(input logic [11:0] v);
    logic [8:0] s;
    s = {1'b0, v[7:0]} + {1'b0, m_loc[7:0]};
    model = v;
`ifdef LOC_FILTER_EN
    if (!m_first && (v[11:8] == m_loc[11:8])) model = {v[11:8], s[8:1]};
`endif
  endfunction

  task automatic expect_commit(input logic [11:0] v);
    logic [11:0] e;
    e = model(v);
    m_loc   = e;
    m_first = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(negedge vclock);
  endtask

  task automatic push(input logic [11:0] v);
    loc_valid = 1'b1;
    loc_in    = v;
    cyc();
    loc_valid = 1'b0;
  endtask

  task automatic strobe(input logic [5:0] v);
    orient_valid = 1'b1;
    orient_in    = v;
    cyc();
    orient_valid = 1'b0;
  endtask

  task automatic frame_start();
    vsync = 1'b0;
    cyc();
  endtask

  task automatic frame_end();
    cyc();
    vsync = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic frame();
    frame_start();
    frame_end();
  endtask

  // Monitor: every new_data pulse must match the oldest expected commit
  initial begin
    forever begin
      @(negedge vclock);
      if (new_data === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_new_data: got location %0h expected no commit", location);
        end else begin
          check("commit_location", 32'(location), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; vsync = 1'b1; loc_in = '0; loc_valid = 1'b0;
    orient_in = '0; orient_valid = 1'b0;
    m_first = 1'b1; m_loc = 12'h000;
    vals[0] = 12'h1A1; vals[1] = 12'h2B2; vals[2] = 12'h3C3;
    vals[3] = 12'h4D4; vals[4] = 12'h5E5;
    repeat (3) cyc();
    check("rst_location", 32'(location), 32'h000);
    check("rst_loc_ready", 32'(loc_ready), 32'd1);
    check("rst_new_data", 32'(new_data), 32'd0);
    check("rst_orientation", 32'(orientation), 32'd0);
    check("rst_orient_ready", 32'(orientation_ready), 32'd0);
    check("rst_stale", 32'(stale), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    repeat (2) cyc();

    // Single commit
    expect_commit(12'h340);
    push(12'h340);
    frame_start();
    check("single_new_data", 32'(new_data), 32'd1);
    check("single_stale", 32'(stale), 32'd0);
    frame_end();
    check("single_new_data_low", 32'(new_data), 32'd0);

    // Reset mid-frame with two entries queued
    push(12'h111);
    push(12'h222);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    m_first = 1'b1; m_loc = 12'h000;
    cyc();
    check("midrst_location", 32'(location), 32'h000);
    check("midrst_loc_ready", 32'(loc_ready), 32'd1);
    frame();
    check("midrst_location_hold", 32'(location), 32'h000);

    // Stale after three empty frames, cleared by a commit
    expect_commit(12'h0AB);
    push(12'h0AB);
    frame();
    frame();
    frame_start();
    check("stale_after2", 32'(stale), 32'd0);
    frame_end();
    frame_start();
    check("stale_after3", 32'(stale), 32'd1);
    frame_end();
    frame();
    check("stale_saturated", 32'(stale), 32'd1);
    expect_commit(12'h0CD);
    push(12'h0CD);
    frame_start();
    check("stale_cleared", 32'(stale), 32'd0);
    frame_end();

    // Overflow: fifth sample dropped, four frames drain in order
    for (int i = 0; i < 4; i++) begin
      expect_commit(vals[i]);
      push(vals[i]);
    end
    check("full_loc_ready", 32'(loc_ready), 32'd0);
    check("full_no_overflow", 32'(overflow), 32'd0);
    push(vals[4]);
    check("overflow_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      frame_start();
      check("drain_location", 32'(location), 32'(vals[i]));
      check("drain_loc_ready", 32'(loc_ready), 32'd1);
      frame_end();
    end
    frame();
    check("overflow_sticky", 32'(overflow), 32'd1);
    check("drain_location_hold", 32'(location), 32'(vals[3]));

    // Orientation: last strobe wins; strobe on tick waits a frame
    strobe(6'd5);
    strobe(6'd9);
    frame_start();
    check("orient_last_wins", 32'(orientation), 32'd9);
    check("orient_ready", 32'(orientation_ready), 32'd1);
    frame_end();
    strobe(6'd20);
    vsync = 1'b0;
    orient_valid = 1'b1;
    orient_in = 6'd12;
    cyc();
    orient_valid = 1'b0;
    check("orient_preedge_shadow", 32'(orientation), 32'd20);
    frame_end();
    frame_start();
    check("orient_deferred", 32'(orientation), 32'd12);
    frame_end();

    // Same-angle sequence (averaged only when the filter is built in)
    expect_commit(12'h210);
    push(12'h210);
    frame();
    expect_commit(12'h221);
    push(12'h221);
    frame_start();
`ifdef LOC_FILTER_EN
    check("filter_same_angle", 32'(location), 32'h218);
`else
    check("filter_same_angle", 32'(location), 32'h221);
`endif
    frame_end();
    expect_commit(12'h530);
    push(12'h530);
    frame_start();
    check("filter_new_angle", 32'(location), 32'h530);
    frame_end();

    repeat (4) cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
